// File: rtl/adder_sum_accumulator.sv
// adder_sum_accumulator
//   Sums a fixed-length batch of 3-bit adder results ({carry, z}, 0..7) into
//   an ACC_W-bit accumulator. At batch end the total is held on a valid/ready
//   output port until the consumer takes it. The overflow flag is sticky for
//   the whole batch.
//
// Build option:
//   ACC_SATURATE_EN  when defined, an overflowing add clamps acc_out to all-ones.
//                    When undefined, the sum wraps modulo 2^ACC_W.
//
// Parameters:
//   ACC_W    accumulator / output width (3..16)
//   COUNT_N  beats per batch (1..255)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   upstream beat handshake
//   z, carry              adder result; beat value = {carry, z}
//   clear                 synchronous abort, discards the current batch
//   out_valid / out_ready downstream total handshake
//   acc_out               registered batch total
//   overflow              sticky per-batch overflow
//   count                 beats accepted in the current batch
module adder_sum_accumulator #(
    parameter int ACC_W   = 8,
    parameter int COUNT_N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       z,
    input  logic             carry,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow,
    output logic [7:0]       count
);

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]       state;
    logic [2:0]       beat;
    logic             accept;
    logic             last;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_nxt;

    // Handshake outputs come straight from the state register, so nothing on
    // the input side can reach an output combinationally.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);

    assign beat   = {carry, z};
    assign accept = in_valid & in_ready;
    assign last   = (count == 8'(COUNT_N - 1));

    // One extra bit on top of the accumulator catches the carry out of the add.
    assign sum = {1'b0, acc_out} + {{(ACC_W-2){1'b0}}, beat};

`ifdef ACC_SATURATE_EN
    // After a clamp every later add overflows again (or adds zero), so the
    // value stays at all-ones for the rest of the batch.
    assign acc_nxt = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_nxt = sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ACCUM;
            acc_out  <= '0;
            overflow <= 1'b0;
            count    <= '0;
        end else if (clear) begin
            // Abort wins over a same-cycle beat or output handshake.
            state    <= ACCUM;
            acc_out  <= '0;
            overflow <= 1'b0;
            count    <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc_out <= acc_nxt;
                        count   <= count + 8'd1;
                        if (sum[ACC_W]) overflow <= 1'b1;
                        if (last) state <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state    <= ACCUM;
                        acc_out  <= '0;
                        overflow <= 1'b0;
                        count    <= '0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Directed bench for adder_sum_accumulator. Two instances share stimulus:
// u8 (ACC_W=8) for totals and handshakes, u4 (ACC_W=4) for overflow cases.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_adder_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] z;
    logic       carry;
    logic       clear;
    logic       out_ready;

    logic       in_ready8, out_valid8, overflow8;
    logic [7:0] acc8, count8;
    logic       in_ready4, out_valid4, overflow4;
    logic [3:0] acc4;
    logic [7:0] count4;

    int checks   = 0;
    int failures = 0;

`ifdef ACC_SATURATE_EN
    localparam int OVF4_EXP = 15;
`else
    localparam int OVF4_EXP = 5;
`endif

    always #5 clk = ~clk;

    adder_sum_accumulator #(.ACC_W(8), .COUNT_N(4)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .z(z), .carry(carry), .clear(clear), .out_valid(out_valid8),
        .out_ready(out_ready), .acc_out(acc8), .overflow(overflow8), .count(count8)
    );

    adder_sum_accumulator #(.ACC_W(4), .COUNT_N(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .z(z), .carry(carry), .clear(clear), .out_valid(out_valid4),
        .out_ready(out_ready), .acc_out(acc4), .overflow(overflow4), .count(count4)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int val);
        in_valid = v;
        {carry, z} = 3'(val);
    endtask

    initial begin
        int b1[4];
        int b2[4];
        rst_n = 1'b0; in_valid = 1'b0; z = 2'd0; carry = 1'b0;
        clear = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_out_valid", out_valid8, 0);
        chk("rst_acc", acc8, 0);
        chk("rst_ovf", overflow8, 0);
        chk("rst_count", count8, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready8, 1);
        step();

        // Basic batch: 3+5+7+1 = 16
        out_ready = 1'b1;
        b1 = '{3, 5, 7, 1};
        foreach (b1[i]) begin
            drive(1'b1, b1[i]);
            step();
            if (i < 3) chk("basic_no_valid", out_valid8, 0);
        end
        drive(1'b0, 0);
        chk("basic_valid", out_valid8, 1);
        chk("basic_acc", acc8, 16);
        chk("basic_ovf", overflow8, 0);
        chk("basic_count", count8, 4);
        chk("basic_in_ready_hold", in_ready8, 0);
        step();
        chk("basic_after_acc", acc8, 0);
        chk("basic_after_count", count8, 0);
        chk("basic_after_in_ready", in_ready8, 1);
        chk("basic_after_valid", out_valid8, 0);

        // Overflow: 7,7,7,0 -> 21 (u8); u4 wraps to 5 or saturates to 15
        out_ready = 1'b0;
        b2 = '{7, 7, 7, 0};
        foreach (b2[i]) begin
            drive(1'b1, b2[i]);
            step();
        end
        chk("ovf4_acc", acc4, OVF4_EXP);
        chk("ovf4_flag", overflow4, 1);
        chk("ovf8_acc", acc8, 21);
        chk("ovf8_flag", overflow8, 0);

        // Backpressure: beat 6 offered while the total is held
        drive(1'b1, 6);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_in_ready", in_ready8, 0);
            chk("bp_valid", out_valid8, 1);
            chk("bp_acc", acc8, 21);
            chk("bp_count", count8, 4);
            chk("bp_ovf4_sticky", overflow4, 1);
        end
        out_ready = 1'b1;
        step();
        chk("bp_hs_valid", out_valid8, 0);
        chk("bp_hs_acc", acc8, 0);
        chk("bp_hs_ovf4", overflow4, 0);
        step();
        chk("bp_first_acc", acc8, 6);
        chk("bp_first_count", count8, 1);

        // Clear mid-batch, then 4,4 and clear with a beat of 2 present
        drive(1'b0, 0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr0_acc", acc8, 0);
        chk("clr0_count", count8, 0);
        drive(1'b1, 4); step();
        drive(1'b1, 4); step();
        chk("clr_pre_acc", acc8, 8);
        chk("clr_pre_count", count8, 2);
        drive(1'b1, 2);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_acc", acc8, 0);
        chk("clr_count", count8, 0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1);
            step();
        end
        drive(1'b0, 0);
        chk("clr_next_acc", acc8, 4);
        chk("clr_next_valid", out_valid8, 1);
        step();
        chk("clr_next_hs", out_valid8, 0);

        // Async reset in HOLD: 7*4 = 28 (u4 overflows)
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 7);
            step();
        end
        drive(1'b0, 0);
        chk("ar_pre_valid", out_valid8, 1);
        chk("ar_pre_acc", acc8, 28);
        chk("ar_pre_ovf4", overflow4, 1);
        #2 rst_n = 1'b0;
        #2;
        chk("ar_valid", out_valid8, 0);
        chk("ar_acc", acc8, 0);
        chk("ar_count", count8, 0);
        chk("ar_ovf4", overflow4, 0);
        #2 rst_n = 1'b1;
        #1;
        chk("ar_in_ready", in_ready8, 1);
        step();

        // Gapped input: 2,2,2,2 with in_valid toggling
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2);
            step();
            chk("gap_count_acc", count8, k + 1);
            if (k < 3) begin
                drive(1'b0, 2);
                step();
                chk("gap_count_idle", count8, k + 1);
                chk("gap_no_valid", out_valid8, 0);
            end
        end
        drive(1'b0, 0);
        chk("gap_valid", out_valid8, 1);
        chk("gap_acc", acc8, 8);
        step();
        chk("gap_hs", out_valid8, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
